// File: rtl/alu_pkg.sv
// alu_pkg: opcode enum and NZVC flag struct shared by alu_core, alu_pipe and the bench.
package alu_pkg;
    typedef enum logic [2:0] {
        ALU_PASS_B   = 3'b000,
        ALU_LSL      = 3'b001,
        ALU_ADD      = 3'b010,
        ALU_SUBTRACT = 3'b011,
        ALU_AND      = 3'b100,
        ALU_OR       = 3'b101,
        ALU_XOR      = 3'b110,
        ALU_LSR      = 3'b111
    } alu_op_t;
    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } alu_flags_t;
endpackage

// File: rtl/alu_if.sv
// alu_if: request/response handshake bundle between register-read, alu_pipe and writeback.
interface alu_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       cntrl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             set_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             negative;
    logic             zero;
    logic             overflow;
    logic             carry_out;
    logic             illegal;
    logic [3:0]       flags_q;
    modport master (
        output in_valid, cntrl, A, B, set_flags, out_ready,
        input  in_ready, out_valid, result, negative, zero, overflow, carry_out, illegal, flags_q
    );
    modport slave (
        input  in_valid, cntrl, A, B, set_flags, out_ready,
        output in_ready, out_valid, result, negative, zero, overflow, carry_out, illegal, flags_q
    );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational opcode/operand evaluation producing result, NZVC flags and illegal.
// LSL/LSR are only legal (and a shifter only exists) when ALU_SHIFT_EN is defined.
module alu_core import alu_pkg::*; #(
    parameter int WIDTH = 64
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags,
    output logic             illegal
);
`ifdef ALU_SHIFT_EN
    localparam int SW = $clog2(WIDTH);
`endif
    logic             arith;
    logic             sub;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    always_comb begin
        sub     = op == ALU_SUBTRACT;
        arith   = op == ALU_ADD || sub;
        bx      = sub ? ~b : b;
        sum     = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(sub);
        illegal = 1'b0;
        result  = '0;
        case (op)
            ALU_PASS_B:             result = b;
            ALU_ADD, ALU_SUBTRACT:  result = sum[WIDTH-1:0];
            ALU_AND:                result = a & b;
            ALU_OR:                 result = a | b;
            ALU_XOR:                result = a ^ b;
`ifdef ALU_SHIFT_EN
            ALU_LSL:                result = a << b[SW-1:0];
            ALU_LSR:                result = a >> b[SW-1:0];
`endif
            default:                illegal = 1'b1;
        endcase
        // Illegal ops fall out as result 0, so N=0 and Z=1 without special-casing.
        flags.n = result[WIDTH-1];
        flags.z = result == '0;
        flags.v = arith && (a[WIDTH-1] == bx[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
        flags.c = arith && sum[WIDTH];
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU (S1 operands, S2 result) with valid/ready and persistent flags_q.
// Build option ALU_SHIFT_EN enables the LSL/LSR opcodes inside alu_core.
module alu_pipe import alu_pkg::*; #(
    parameter int WIDTH = 64
) (
    input logic  clk,
    input logic  reset,
    alu_if.slave bus
);
    logic             s1_valid, s1_set, s2_set, s2_adv, s1_adv;
    logic             out_valid_q, illegal_n, illegal_q;
    alu_op_t          s1_op;
    logic [WIDTH-1:0] s1_a, s1_b, result_n, result_q;
    alu_flags_t       flags_n, flags_s2, flags_p;
    assign s2_adv = !out_valid_q || bus.out_ready;
    assign s1_adv = !s1_valid || s2_adv;
    alu_core #(.WIDTH(WIDTH)) core (
        .op      (s1_op),
        .a       (s1_a),
        .b       (s1_b),
        .result  (result_n),
        .flags   (flags_n),
        .illegal (illegal_n)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_op       <= ALU_PASS_B;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_set      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_s2    <= '0;
            illegal_q   <= 1'b0;
            s2_set      <= 1'b0;
            flags_p     <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
                s1_op    <= alu_op_t'(bus.cntrl);
                s1_a     <= bus.A;
                s1_b     <= bus.B;
                s1_set   <= bus.set_flags;
            end
            // S2 only reloads from a valid S1 so a drained pipe keeps its last result visible.
            if (s2_adv) begin
                out_valid_q <= s1_valid;
                if (s1_valid) begin
                    result_q  <= result_n;
                    flags_s2  <= flags_n;
                    illegal_q <= illegal_n;
                    s2_set    <= s1_set;
                end
            end
            if (out_valid_q && bus.out_ready && s2_set && !illegal_q)
                flags_p <= flags_s2;
        end
    end
    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.negative  = flags_s2.n;
    assign bus.zero      = flags_s2.z;
    assign bus.overflow  = flags_s2.v;
    assign bus.carry_out = flags_s2.c;
    assign bus.illegal   = illegal_q;
    assign bus.flags_q   = flags_p;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed scoreboard bench for alu_pipe; stimulus pushes expectations, a monitor pops on transfer.
module tb_alu_pipe;
    localparam int W = 64;
    typedef struct {
        logic [W-1:0] r;
        logic [3:0]   f;
        logic         ill;
        logic         lat;
        int           acc;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t q[$];
    exp_t m_e;
    logic [W-1:0] held;
    alu_if #(.WIDTH(W)) bus ();
    alu_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    always @(negedge clk) cyc++;

    task automatic check(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic sf,
                        input logic [W-1:0] r, input logic [3:0] f, input logic ill, input logic lat);
        logic rdy;
        exp_t e;
        bus.in_valid  = 1'b1;
        bus.cntrl     = op;
        bus.A         = a;
        bus.B         = b;
        bus.set_flags = sf;
        for (int i = 0; i < 50; i++) begin
            #1 rdy = bus.in_ready;
            @(posedge clk);
            if (rdy) begin
                e.r = r; e.f = f; e.ill = ill; e.lat = lat; e.acc = cyc;
                q.push_back(e);
                @(negedge clk);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        total++; bad++;
        $display("FAIL accept_timeout: op %b never accepted", op);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) begin
            @(negedge clk);
            #3;
        end
        check("drain_empty", W'(q.size()), 0);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'b000:  ref_op = b;
            3'b100:  ref_op = a & b;
            3'b101:  ref_op = a | b;
            default: ref_op = a ^ b;
        endcase
    endfunction

    initial forever begin
        @(negedge clk);
        #2;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_output: got result %h with no op pending", bus.result);
            end else begin
                m_e = q.pop_front();
                check("result", bus.result, m_e.r);
                check("flags_nzvc", W'({bus.negative, bus.zero, bus.overflow, bus.carry_out}), W'(m_e.f));
                check("illegal", W'(bus.illegal), W'(m_e.ill));
                if (m_e.lat) check("latency", W'(cyc - m_e.acc), 2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   ops [4];
        logic [2:0]   op;
        logic [W-1:0] a, b, r;
        ops = '{3'b000, 3'b100, 3'b101, 3'b110};
        bus.in_valid = 1'b0; bus.cntrl = 3'b000; bus.A = '0; bus.B = '0;
        bus.set_flags = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", W'(bus.in_ready), 1);
        check("rst_out_valid", W'(bus.out_valid), 0);
        check("rst_result", bus.result, 0);
        check("rst_flags", W'({bus.negative, bus.zero, bus.overflow, bus.carry_out, bus.illegal}), 0);
        check("rst_flags_q", W'(bus.flags_q), 0);
        @(negedge clk);

        send(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 4'b1010, 1'b0, 1'b1);
        drain();
        check("add_flags_q", W'(bus.flags_q), W'(4'b1010));

        send(3'b011, 64'd5, 64'd5, 1'b1, 64'd0, 4'b0101, 1'b0, 1'b1);
        send(3'b011, 64'd0, 64'd1, 1'b0, {W{1'b1}}, 4'b1000, 1'b0, 1'b1);
        drain();
        check("sub_flags_q", W'(bus.flags_q), W'(4'b0101));

        bus.out_ready = 1'b0;
        send(3'b010, 64'd1, 64'd1, 1'b0, 64'd2, 4'b0000, 1'b0, 1'b0);
        send(3'b010, 64'd2, 64'd2, 1'b0, 64'd4, 4'b0000, 1'b0, 1'b0);
        #1;
        check("stall_in_ready", W'(bus.in_ready), 0);
        check("stall_out_valid", W'(bus.out_valid), 1);
        held = bus.result;
        bus.in_valid = 1'b1; bus.cntrl = 3'b010; bus.A = 64'd3; bus.B = 64'd3;
        @(negedge clk);
        #1;
        check("stall_hold_result", bus.result, held);
        check("stall_hold_ready", W'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        send(3'b010, 64'd3, 64'd3, 1'b0, 64'd6, 4'b0000, 1'b0, 1'b0);
        drain();

`ifdef ALU_SHIFT_EN
        send(3'b001, 64'd1, 64'd63, 1'b1, 64'h8000_0000_0000_0000, 4'b1000, 1'b0, 1'b1);
        send(3'b111, 64'h8000_0000_0000_0000, 64'd63, 1'b0, 64'd1, 4'b0000, 1'b0, 1'b1);
        drain();
        check("shift_flags_q", W'(bus.flags_q), W'(4'b1000));
`else
        send(3'b001, 64'd1, 64'd63, 1'b1, 64'd0, 4'b0100, 1'b1, 1'b1);
        send(3'b111, 64'h8000_0000_0000_0000, 64'd63, 1'b1, 64'd0, 4'b0100, 1'b1, 1'b1);
        drain();
        check("illegal_flags_q", W'(bus.flags_q), W'(4'b0101));
`endif

        bus.out_ready = 1'b0;
        send(3'b010, 64'd1, 64'd2, 1'b1, 64'd3, 4'b0000, 1'b0, 1'b0);
        send(3'b010, 64'd3, 64'd4, 1'b1, 64'd7, 4'b0000, 1'b0, 1'b0);
        #3 reset = 1'b1;
        #1;
        check("midrst_out_valid", W'(bus.out_valid), 0);
        check("midrst_flags_q", W'(bus.flags_q), 0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check("midrst_no_stale", W'(bus.out_valid), 0);
            @(negedge clk);
        end

        a = $urandom();
        send(3'b110, {a, a[31:0]}, {a, a[31:0]}, 1'b1, 64'd0, 4'b0100, 1'b0, 1'b1);
        for (int i = 0; i < 25; i++) begin
            op = ops[$urandom_range(0, 3)];
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            r = ref_op(op, a, b);
            send(op, a, b, 1'b0, r, {r[W-1], r == '0, 2'b00}, 1'b0, 1'b1);
        end
        drain();
        check("stream_flags_q", W'(bus.flags_q), W'(4'b0100));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
